wb_pwm_fader: RTL and testbench

WB_PWM_FADER -- requirements
Module: wb_pwm_fader

---
 rtl/wb_pwm_fader_pkg.sv | 17 +
 rtl/wb_pwm_fader_tick.sv | 30 +++
 rtl/wb_pwm_fader.sv | 176 +++++++++++++++++
 tb/tb_wb_pwm_fader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pwm_fader_pkg.sv
// Shared types and defaults for the Wishbone PWM fader: FSM states, register map
// constants and default parameter values.
package wb_pwm_fader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REQ,
        WAIT
    } fsm_state_e;

    localparam logic [3:0]  ADR_PERIOD      = 4'hF;
    localparam int unsigned BIT_NUM_DEF     = 4;
    localparam int unsigned CHANNEL_NUM_DEF = 3;
    localparam int unsigned PERIOD_W_DEF    = 16;

endpackage

// File: rtl/wb_pwm_fader_tick.sv
// Fade-step prescaler: counts 0..period and pulses tick_o on the wrap cycle.
module wb_pwm_fader_tick
    import wb_pwm_fader_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    // >= so a period reprogrammed below the running count wraps immediately
    assign tick_o = (cnt_q >= period_i);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_pwm_fader.sv
// Wishbone-configured fader: steps each channel's duty value one LSB per tick toward
// its target, pushing every new value to a PWM slave over a Wishbone master port.
module wb_pwm_fader
    import wb_pwm_fader_pkg::*;
#(
    parameter int unsigned BIT_NUM     = BIT_NUM_DEF,
    parameter int unsigned CHANNEL_NUM = CHANNEL_NUM_DEF,
    parameter int unsigned PERIOD_W    = PERIOD_W_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic        m_stall_i
);

    localparam int unsigned     CH_W    = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNEL_NUM - 1);

    fsm_state_e          state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BIT_NUM-1:0]  nxt_q, nxt_d;
    logic                pending_q, pending_d;
    logic [BIT_NUM-1:0]  cur_q [CHANNEL_NUM];
    logic [BIT_NUM-1:0]  cur_d [CHANNEL_NUM];
    logic [BIT_NUM-1:0]  tgt_q [CHANNEL_NUM];
    logic [PERIOD_W-1:0] period_q;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic [31:0]         rd_data;
    logic                wr_en;
    logic                tick;
    logic                scan_done;
    logic [31:0]         unused_wb_dat;

    assign unused_wb_dat = wb_dat_i;
    assign wb_stall_o    = 1'b0;
    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;
    assign wr_en         = wb_cyc_i & wb_stb_i & wb_we_i;

    wb_pwm_fader_tick #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .period_i (period_q),
        .tick_o   (tick)
    );

    always_comb begin
        rd_data = '0;
        if (wb_cyc_i && wb_stb_i && !wb_we_i) begin
            if (wb_adr_i == ADR_PERIOD) begin
                rd_data[PERIOD_W-1:0] = period_q;
            end
            for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
                if (wb_adr_i == 4'(i)) begin
                    rd_data[BIT_NUM-1:0] = tgt_q[i];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tgt_q    <= '{default: '0};
            period_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            ack_q <= wb_cyc_i & wb_stb_i;
            dat_q <= rd_data;
            if (wr_en) begin
                if (wb_adr_i == ADR_PERIOD) begin
                    period_q <= wb_dat_i[PERIOD_W-1:0];
                end
                for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
                    if (wb_adr_i == 4'(i)) begin
                        tgt_q[i] <= wb_dat_i[BIT_NUM-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        nxt_d     = nxt_q;
        cur_d     = cur_q;
        scan_done = 1'b0;
        m_cyc_o   = 1'b0;
        m_stb_o   = 1'b0;
        m_we_o    = 1'b0;
        m_adr_o   = '0;
        m_dat_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d = SCAN;
                    ch_d    = '0;
                end
            end
            SCAN: begin
                if (cur_q[ch_q] != tgt_q[ch_q]) begin
                    nxt_d   = (cur_q[ch_q] < tgt_q[ch_q]) ? cur_q[ch_q] + 1'b1
                                                          : cur_q[ch_q] - 1'b1;
                    state_d = REQ;
                end else if (ch_q == LAST_CH) begin
                    state_d   = IDLE;
                    ch_d      = '0;
                    scan_done = 1'b1;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            REQ: begin
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_adr_o = 4'(ch_q);
                m_dat_o = 32'(nxt_q);
                if (!m_stall_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                m_cyc_o = 1'b1;
                if (m_ack_i) begin
                    cur_d[ch_q] = nxt_q;
                    if (ch_q == LAST_CH) begin
                        state_d   = IDLE;
                        ch_d      = '0;
                        scan_done = 1'b1;
                    end else begin
                        state_d = SCAN;
                        ch_d    = ch_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // a tick landing on the pass-completion cycle must not be lost
        pending_d = tick ? 1'b1 : (scan_done ? 1'b0 : pending_q);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            nxt_q     <= '0;
            pending_q <= 1'b0;
            cur_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            nxt_q     <= nxt_d;
            pending_q <= pending_d;
            cur_q     <= cur_d;
        end
    end

endmodule

// File: tb/tb_wb_pwm_fader.sv
// Directed + randomized bench for wb_pwm_fader with a per-channel value model and a
// responsive PWM-slave model on the master port.
module tb_wb_pwm_fader;

    localparam int unsigned CN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o, wb_stall_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_ack_i, m_stall_i;

    int compared = 0;
    int mism     = 0;
    int cyc_cnt  = 0;
    int tgt_m [CN];
    int cur_m [CN];
    int wr_adr [$];
    int wr_dat [$];
    int wr_cyc [$];
    bit ack_en   = 1'b1;
    bit acc_prev = 1'b0;

    wb_pwm_fader #(
        .BIT_NUM     (4),
        .CHANNEL_NUM (CN),
        .PERIOD_W    (16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_stall_o (wb_stall_o),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_we_o     (m_we_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_ack_i    (m_ack_i),
        .m_stall_i  (m_stall_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: accepts when stb && !stall, acks one cycle later; each accepted
    // write must be exactly one step from the model value toward the model target.
    always @(negedge clk) begin
        bit acc;
        int a;
        int e;
        acc = !rst && m_cyc_o && m_stb_o && !m_stall_i;
        if (ack_en) m_ack_i = acc_prev;
        acc_prev = acc;
        if (acc) begin
            a = int'(m_adr_o);
            e = -1;
            if (a < CN && cur_m[a] != tgt_m[a])
                e = (cur_m[a] < tgt_m[a]) ? cur_m[a] + 1 : cur_m[a] - 1;
            check("m_dat_step", m_dat_o, e);
            check("m_we", m_we_o, 1);
            if (e >= 0) cur_m[a] = e;
            wr_adr.push_back(a);
            wr_dat.push_back(int'(m_dat_o));
            wr_cyc.push_back(cyc_cnt);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
        step();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check("wr_ack", wb_ack_o, 1);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
        step();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("rd_ack", wb_ack_o, 1);
        d = wb_dat_o;
    endtask

    task automatic wait_writes(input int n, input int budget, input int idle);
        for (int i = 0; i < budget && wr_dat.size() < n; i++) step();
        step(idle);
        check("wr_count", wr_dat.size(), n);
    endtask

    initial begin
        logic [31:0] rd;
        int base, mx, d0, exp_n, t, dd;

        rst = 1'b1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0;
        m_ack_i = 0; m_stall_i = 0;
        for (int c = 0; c < CN; c++) begin tgt_m[c] = 0; cur_m[c] = 0; end
        #2;
        check("rst_m_cyc", m_cyc_o, 0);
        check("rst_m_stb", m_stb_o, 0);
        check("rst_m_adr_dat", {m_we_o, m_adr_o, m_dat_o[26:0]}, 0);
        check("rst_wb_ack", wb_ack_o, 0);
        check("rst_wb_dat", wb_dat_o, 0);
        check("rst_stall", wb_stall_o, 0);
        step(2);
        rst = 1'b0;
        step();

        // period 0, target[1]=5: five single-step writes then quiet
        wb_write(4'hF, 0);
        base = wr_dat.size();
        wb_write(4'h1, 5); tgt_m[1] = 5;
        wait_writes(base + 5, 300, 30);
        for (int i = 0; i < 5; i++) begin
            if (base + i < wr_dat.size()) begin
                check("t1_adr", wr_adr[base + i], 1);
                check("t1_dat", wr_dat[base + i], i + 1);
            end
        end
        wb_read(4'h1, rd);
        check("t1_rd_tgt", rd, 5);

        // period 3: writes at least 4 cycles apart
        wb_write(4'hF, 3);
        base = wr_dat.size();
        wb_write(4'h0, 2); tgt_m[0] = 2;
        wait_writes(base + 2, 300, 40);
        if (wr_dat.size() >= base + 2) begin
            check("t2_gap", (wr_cyc[base + 1] - wr_cyc[base]) >= 4, 1);
            check("t2_last", wr_dat[base + 1], 2);
        end

        // retarget mid-fade: 15 then 12 once 8 is written
        wb_write(4'hF, 2);
        base = wr_dat.size();
        wb_write(4'h0, 15); tgt_m[0] = 15;
        for (int i = 0; i < 400 && !(wr_dat.size() > base && wr_dat[$] == 8); i++) step();
        check("t3_saw8", (wr_dat.size() > base && wr_dat[$] == 8), 1);
        wb_write(4'h0, 12); tgt_m[0] = 12;
        wait_writes(base + 10, 500, 40);
        mx = 0;
        for (int i = base; i < wr_dat.size(); i++) if (wr_dat[i] > mx) mx = wr_dat[i];
        check("t3_max", mx, 12);
        check("t3_last", wr_dat[$], 12);

        // stall held during REQ
        wb_write(4'hF, 20);
        m_stall_i = 1'b1;
        base = wr_dat.size();
        wb_write(4'h2, 1); tgt_m[2] = 1;
        for (int i = 0; i < 100 && !m_stb_o; i++) step();
        check("t4_stb_seen", m_stb_o, 1);
        d0 = int'(m_dat_o);
        for (int i = 0; i < 5; i++) begin
            check("t4_stb_hold", m_stb_o, 1);
            check("t4_dat_hold", m_dat_o, d0);
            check("t4_adr_hold", m_adr_o, 2);
            step();
        end
        m_stall_i = 1'b0;
        wait_writes(base + 1, 50, 60);
        check("t4_dat", d0, 1);

        // reset while waiting for ack; late ack ignored
        wb_write(4'hF, 0);
        ack_en = 1'b0; m_ack_i = 1'b0;
        wb_write(4'h2, 0); tgt_m[2] = 0;
        for (int i = 0; i < 50 && !(m_cyc_o && !m_stb_o); i++) step();
        check("t5_in_wait", m_cyc_o && !m_stb_o, 1);
        step(2);
        rst = 1'b1;
        #1;
        check("t5_cyc_drop", m_cyc_o, 0);
        check("t5_m_out_zero", {m_stb_o, m_we_o, m_adr_o, m_dat_o[25:0]}, 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < CN; c++) begin tgt_m[c] = 0; cur_m[c] = 0; end
        base = wr_dat.size();
        m_ack_i = 1'b1;
        step();
        m_ack_i = 1'b0;
        ack_en = 1'b1;
        step(20);
        check("t5_cyc_quiet", m_cyc_o, 0);
        check("t5_no_writes", wr_dat.size(), base);
        for (int c = 0; c < CN; c++) begin
            wb_read(4'(c), rd);
            check("t5_rd_tgt", rd, 0);
        end
        wb_read(4'hF, rd);
        check("t5_rd_period", rd, 0);

        // period readback timing and unmapped addresses
        wb_write(4'hF, 32'h1234);
        wb_write(4'h3, 32'h7);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'hF;
        step();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("t6_ack", wb_ack_o, 1);
        check("t6_period", wb_dat_o, 32'h1234);
        step();
        check("t6_ack_drop", wb_ack_o, 0);
        wb_read(4'hE, rd);
        check("t6_rd_E", rd, 0);
        wb_read(4'h3, rd);
        check("t6_rd_3", rd, 0);

        // randomized retargeting of all channels
        for (int r = 0; r < 4; r++) begin
            wb_write(4'hF, $urandom_range(0, 2));
            base  = wr_dat.size();
            exp_n = 0;
            for (int c = 0; c < CN; c++) begin
                t  = int'($urandom_range(0, 15));
                dd = t - cur_m[c];
                exp_n += (dd < 0) ? -dd : dd;
                wb_write(4'(c), t); tgt_m[c] = t;
            end
            wait_writes(base + exp_n, 3000, 40);
            for (int c = 0; c < CN; c++) begin
                wb_read(4'(c), rd);
                check("rnd_rd_tgt", rd, tgt_m[c]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
